// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: consumes a byte stream (count, LE words, XOR checksum),
// writes each word into instruction memory and releases the CPU once the image is verified.
module imem_loader #(
   parameter int Nloc  = 64,
   parameter int Dbits = 32
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       byte_valid,
   input  logic [7:0]                 byte_data,
   output logic                       byte_ready,
   output logic                       mem_wr,
   output logic [$clog2(Nloc)-1:0]    mem_addr,
   output logic [Dbits-1:0]           mem_din,
   output logic                       cpu_hold,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [$clog2(Nloc+1)-1:0]  words_loaded
);

   localparam int AW = $clog2(Nloc);
   localparam int CW = $clog2(Nloc+1);
   localparam logic [15:0] NLOC16 = 16'(Nloc);

   typedef enum logic [2:0] {
      IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR
   } state_t;

   state_t            state_reg, state_next;
   logic [15:0]       hdr_reg;
   logic [7:0]        csum_reg;
   logic [1:0]        byte_idx_reg;
   logic [Dbits-1:0]  word_reg;
   logic [Dbits-1:0]  word_next;
   logic [15:0]       hdr_full;
   logic [15:0]       wl_inc;
   logic              accept;
   logic              accept_data;

   // Outputs decode the state register only, so byte_ready has no path from byte_valid.
   assign byte_ready  = (state_reg == HDR0) || (state_reg == HDR1) ||
                        (state_reg == DATA) || (state_reg == CSUM);
   assign busy        = byte_ready || (state_reg == WRITE);
   assign mem_wr      = (state_reg == WRITE);
   assign done        = (state_reg == DONE);
   assign error       = (state_reg == ERR);
   assign cpu_hold    = (state_reg != DONE);

   assign accept      = byte_valid && byte_ready;
   assign accept_data = accept && (state_reg == DATA);
   assign hdr_full    = {byte_data, hdr_reg[7:0]};
   assign wl_inc      = 16'(words_loaded) + 16'd1;

   // Little-endian lane steering: the accepted byte lands in lane byte_idx.
   generate
      for (genvar gi = 0; gi < Dbits/8; gi++) begin : g_lane
         assign word_next[8*gi +: 8] = (accept_data && byte_idx_reg == 2'(gi)) ?
                                       byte_data : word_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE, ERR: if (start) state_next = HDR0;
         HDR0:            if (accept) state_next = HDR1;
         HDR1: begin
            if (accept) begin
               if (hdr_full > NLOC16)     state_next = ERR;
               else if (hdr_full == '0)   state_next = CSUM;
               else                       state_next = DATA;
            end
         end
         DATA:            if (accept && byte_idx_reg == 2'd3) state_next = WRITE;
         WRITE:           state_next = (wl_inc == hdr_reg) ? CSUM : DATA;
         CSUM: begin
            if (accept) state_next = (byte_data == csum_reg) ? DONE : ERR;
         end
         default:         state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hdr_reg      <= '0;
         csum_reg     <= '0;
         byte_idx_reg <= '0;
         word_reg     <= '0;
         words_loaded <= '0;
         mem_addr     <= '0;
         mem_din      <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE, ERR: begin
               if (start) begin
                  hdr_reg      <= '0;
                  csum_reg     <= '0;
                  byte_idx_reg <= '0;
                  words_loaded <= '0;
               end
            end
            HDR0: if (accept) hdr_reg[7:0]  <= byte_data;
            HDR1: if (accept) hdr_reg[15:8] <= byte_data;
            DATA: begin
               if (accept) begin
                  word_reg     <= word_next;
                  csum_reg     <= csum_reg ^ byte_data;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  // Address/data are captured here so they are stable for the whole WRITE cycle.
                  if (byte_idx_reg == 2'd3) begin
                     mem_addr <= words_loaded[AW-1:0];
                     mem_din  <= word_next;
                  end
               end
            end
            WRITE: words_loaded <= words_loaded + CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of images plus reset-abort and long gapped-load sequences.
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, mem_wr, cpu_hold, busy, done, error;
   logic [5:0]  mem_addr;
   logic [31:0] mem_din;
   logic [6:0]  words_loaded;

   imem_loader #(.Nloc(64), .Dbits(32)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [5:0]  wa_q[$];
   logic [31:0] wd_q[$];

   // WRITE lasts one cycle, so each pulse is seen at exactly one falling edge.
   always @(negedge clock) begin
      if (mem_wr) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_din);
      end
   end

   typedef struct {
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  cs;
      logic        exp_done;
      logic        exp_err;
      int          exp_wl;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!byte_ready) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: byte_ready=0 after %0d cycles, required 1", n);
         byte_valid = 1'b0;
      end else begin
         @(negedge clock);
         byte_valid = 1'b0;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [31:0] w;
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      chk($sformatf("v%0d_start_busy", idx), busy, 1'b1);
      chk($sformatf("v%0d_start_done", idx), done, 1'b0);
      chk($sformatf("v%0d_start_hold", idx), cpu_hold, 1'b1);
      send_byte(v.n[7:0]);
      send_byte(v.n[15:8]);
      if (v.n <= 16'd64) begin
         for (int i = 0; i < int'(v.n); i++) begin
            w = (i == 0) ? v.w0 : v.w1;
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
         end
         send_byte(v.cs);
      end
      @(negedge clock);
      chk($sformatf("v%0d_done", idx), done, v.exp_done);
      chk($sformatf("v%0d_error", idx), error, v.exp_err);
      chk($sformatf("v%0d_hold", idx), cpu_hold, !v.exp_done);
      chk($sformatf("v%0d_busy", idx), busy, 1'b0);
      chk($sformatf("v%0d_ready", idx), byte_ready, 1'b0);
      chk($sformatf("v%0d_wl", idx), 32'(words_loaded), 32'(v.exp_wl));
      chk($sformatf("v%0d_nwr", idx), 32'(wa_q.size()), 32'(v.exp_wl));
      for (int i = 0; i < v.exp_wl && i < wa_q.size(); i++) begin
         chk($sformatf("v%0d_addr%0d", idx, i), 32'(wa_q[i]), 32'(i));
         chk($sformatf("v%0d_data%0d", idx, i), wd_q[i], (i == 0) ? v.w0 : v.w1);
      end
   endtask

   logic [31:0] exp_w[64];
   logic [7:0]  lcs;
   logic [7:0]  iv;

   initial begin
      vecs[0] = '{16'd2,      32'h12345678, 32'hDEADBEEF, 8'h2A, 1'b1, 1'b0, 2};
      vecs[1] = '{16'd2,      32'h12345678, 32'hDEADBEEF, 8'h01, 1'b0, 1'b1, 2};
      vecs[2] = '{16'h0041,   32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 0};
      vecs[3] = '{16'd0,      32'h0,        32'h0,        8'h00, 1'b1, 1'b0, 0};
      vecs[4] = '{16'd0,      32'h0,        32'h0,        8'h5A, 1'b0, 1'b1, 0};
      vecs[5] = '{16'd1,      32'h01020304, 32'h0,        8'h04, 1'b1, 1'b0, 1};
      vecs[6] = '{16'hFFFF,   32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 0};

      repeat (3) @(negedge clock);
      chk("rst_hold", cpu_hold, 1'b1);
      chk("rst_ready", byte_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_wr", mem_wr, 1'b0);
      chk("rst_wl", 32'(words_loaded), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_din", mem_din, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle_ready", byte_ready, 1'b0);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Asynchronous reset with two of four data bytes taken.
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h78);
      send_byte(8'h56);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_hold", cpu_hold, 1'b1);
      chk("arst_done", done, 1'b0);
      chk("arst_ready", byte_ready, 1'b0);
      chk("arst_din", mem_din, 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      chk("arst_nwr", 32'(wa_q.size()), 32'd0);
      chk("arst_wl", 32'(words_loaded), 32'd0);
      run_vec(10, vecs[0]);

      // Full 64-word image with random source gaps and ignored start pulses.
      wa_q.delete();
      wd_q.delete();
      lcs = 8'h00;
      for (int i = 0; i < 64; i++) begin
         iv = 8'(i);
         exp_w[i] = {iv + 8'h11, iv ^ 8'hC3, ~iv, iv};
         lcs = lcs ^ exp_w[i][7:0] ^ exp_w[i][15:8] ^ exp_w[i][23:16] ^ exp_w[i][31:24];
      end
      pulse_start();
      send_byte(8'h40);
      send_byte(8'h00);
      for (int i = 0; i < 64; i++) begin
         if (i == 10 || i == 50) pulse_start();
         for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send_byte(exp_w[i][8*k +: 8]);
         end
      end
      send_byte(lcs);
      @(negedge clock);
      chk("big_nwr", 32'(wa_q.size()), 32'd64);
      for (int i = 0; i < 64 && i < wa_q.size(); i++) begin
         chk($sformatf("big_addr%0d", i), 32'(wa_q[i]), 32'(i));
         chk($sformatf("big_data%0d", i), wd_q[i], exp_w[i]);
      end
      chk("big_done", done, 1'b1);
      chk("big_hold", cpu_hold, 1'b0);
      chk("big_wl", 32'(words_loaded), 32'd64);
      chk("big_last_addr", 32'(mem_addr), 32'd63);
      chk("big_last_din", mem_din, exp_w[63]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule
